// File: rtl/tick_gen.sv
// Multi-channel tick generator: per-channel programmable divisor, periodic or
// armable one-shot, producing a one-cycle tick enable and a toggling level.
module tick_gen #(
  parameter int unsigned WIDTH    = 26,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_div,
  input  logic                load_mode,
  input  logic [CHANNELS-1:0] arm,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] busy
);

  // Out-of-range channel numbers drop the whole load.
  logic load_ok_c;
  assign load_ok_c = load && (32'(load_ch) < CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] cnt_q;
    logic             mode_q;
    logic             tick_q;
    logic             level_q;
    logic             busy_q;
    logic             sel_c;
    logic             run_c;
    logic             wrap_c;

    assign sel_c  = load_ok_c && (32'(load_ch) == 32'(g));
    assign run_c  = enable && (div_q != '0) && (!mode_q || busy_q);
    assign wrap_c = (cnt_q == div_q - WIDTH'(1));

    // Priority per channel: load, then arm, then count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        div_q   <= '0;
        cnt_q   <= '0;
        mode_q  <= 1'b0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (sel_c) begin
        div_q   <= load_div;
        mode_q  <= load_mode;
        cnt_q   <= '0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (arm[g]) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        if (mode_q && (div_q != '0)) begin
          busy_q <= 1'b1;
        end
      end else if (run_c) begin
        if (wrap_c) begin
          cnt_q   <= '0;
          tick_q  <= 1'b1;
          level_q <= ~level_q;
          if (mode_q) begin
            busy_q <= 1'b0;
          end
        end else begin
          cnt_q  <= cnt_q + WIDTH'(1);
          tick_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick[g]  = tick_q;
    assign level[g] = level_q;
    assign busy[g]  = busy_q;
  end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a countdown reference model predicts every
// cycle's outputs; a monitor pops and compares after each rising edge.
module tb_tick_gen;
  localparam int unsigned W   = 8;
  localparam int unsigned NCH = 5;
  localparam int unsigned CW  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           load;
  logic [CW-1:0]  load_ch;
  logic [W-1:0]   load_div;
  logic           load_mode;
  logic [NCH-1:0] arm;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] level;
  logic [NCH-1:0] busy;

  tick_gen #(.WIDTH(W), .CHANNELS(NCH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_ch(load_ch),
    .load_div(load_div), .load_mode(load_mode), .arm(arm),
    .tick(tick), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last1 = 0;
  int prev1 = 0;

  // Reference model: cycles remaining until the next tick.
  int m_div [NCH];
  bit m_mode[NCH];
  int m_rem [NCH];
  bit m_lvl [NCH];
  bit m_bsy [NCH];
  bit m_tk  [NCH];

  logic [3*NCH-1:0] exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = 0; m_mode[i] = 0; m_rem[i] = 0;
      m_lvl[i] = 0; m_bsy[i] = 0; m_tk[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      if (load && int'(load_ch) < NCH && int'(load_ch) == i) begin
        m_div[i] = int'(load_div); m_mode[i] = load_mode; m_rem[i] = int'(load_div);
        m_lvl[i] = 0; m_bsy[i] = 0; m_tk[i] = 0;
      end else if (arm[i]) begin
        m_rem[i] = m_div[i];
        m_tk[i]  = 0;
        if (m_mode[i] && m_div[i] != 0) m_bsy[i] = 1;
      end else if (enable && m_div[i] != 0 && (!m_mode[i] || m_bsy[i])) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_tk[i] = 1; m_lvl[i] = !m_lvl[i]; m_rem[i] = m_div[i];
          if (m_mode[i]) m_bsy[i] = 0;
        end else begin
          m_tk[i] = 0;
        end
      end else begin
        m_tk[i] = 0;
      end
    end
  endtask

  function automatic logic [3*NCH-1:0] model_pack();
    logic [NCH-1:0] t, l, b;
    for (int i = 0; i < NCH; i++) begin
      t[i] = m_tk[i]; l[i] = m_lvl[i]; b[i] = m_bsy[i];
    end
    return {t, l, b};
  endfunction

  // Apply current inputs for one edge; strobes clear afterwards.
  task automatic run_cycle();
    model_step();
    exp_q.push_back(model_pack());
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    arm  = '0;
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic do_load(input int ch, input int d, input bit m);
    load = 1'b1; load_ch = CW'(ch); load_div = W'(d); load_mode = m;
    run_cycle();
  endtask

  task automatic do_arm(input int ch);
    arm = '0;
    arm[ch] = 1'b1;
    run_cycle();
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({tick, level, busy} !== '0) begin
      miscompares++;
      $display("FAIL %s: got tick=%b level=%b busy=%b, expected all zero", name, tick, level, busy);
    end
  endtask

  // Monitor: every output cycle is compared against the queued prediction.
  initial begin
    logic [3*NCH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (tick[1]) begin
        prev1 = last1;
        last1 = cyc;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({tick, level, busy} !== e) begin
          miscompares++;
          $display("FAIL cycle %0d outputs: got tick=%b level=%b busy=%b, expected tick=%b level=%b busy=%b",
                   cyc, tick, level, busy, e[3*NCH-1:2*NCH], e[2*NCH-1:NCH], e[NCH-1:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_ch = '0;
    load_div = '0; load_mode = 1'b0; arm = '0;
    model_clear();
    #1;
    check_zero("reset_initial");
    @(posedge clk); @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    reset = 1'b0;

    // Periodic rates; ch3 stays at D=0.
    enable = 1'b1;
    do_load(0, 1, 0);
    do_load(1, 3, 0);
    do_load(2, 10, 0);
    run_n(45);

    // Asynchronous reset between edges, then silence without loads.
    #2;
    reset = 1'b1;
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_async_edge");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 100; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      arm = NCH'($urandom_range(0, 31));
      run_cycle();
    end

    // Freeze: enable low for 7 cycles right after a ch1 tick.
    enable = 1'b1;
    do_load(1, 5, 0);
    n = 0;
    while (!m_tk[1] && n < 20) begin run_cycle(); n++; end
    enable = 1'b0;
    run_n(7);
    enable = 1'b1;
    n = 0;
    run_cycle();
    while (!m_tk[1] && n < 20) begin run_cycle(); n++; end
    vectors++;
    if (last1 - prev1 != 12) begin
      miscompares++;
      $display("FAIL freeze_gap: got %0d cycles between ticks, expected 12", last1 - prev1);
    end
    run_n(6);

    // One-shot, re-arm mid-count, and arm with D=0.
    do_load(2, 4, 1);
    do_arm(2);
    run_n(8);
    do_arm(2);
    run_n(1);
    do_arm(2);
    run_n(8);
    do_load(3, 0, 1);
    do_arm(3);
    run_n(3);
    enable = 1'b0;
    do_arm(2);
    run_n(3);
    enable = 1'b1;
    run_n(6);

    // Simultaneous events.
    arm = 5'b00001;
    do_load(0, 5, 1);
    run_n(3);
    do_load(5, 7, 0);
    do_load(7, 2, 1);
    run_n(3);
    do_load(1, 9, 0);
    run_n(7);
    do_load(1, 3, 0);
    run_n(8);

    // Realign a periodic channel at an arbitrary point.
    do_load(0, 8, 0);
    run_n($urandom_range(1, 20));
    do_arm(0);
    run_n(30);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) begin
        load = 1'b1;
        load_ch = CW'($urandom_range(0, 7));
        load_div = W'($urandom_range(0, 12));
        load_mode = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NCH; i++) arm[i] = ($urandom_range(0, 15) == 0);
      run_cycle();
    end

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
